// File: rtl/seven_segment_reader.sv
// Recovers digit values from a multiplexed active-high seven-segment bus.
// Each activation is sampled once after a settle delay, then filtered per digit.
module seven_segment_reader #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3,
  parameter int STABLE = 2,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digit_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  frame_valid,
  output logic                  err,
  output logic [IW-1:0]         err_digit
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam int STW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

  state_t            state_reg, state_next;
  logic [SCW-1:0]    settle_cnt_reg, settle_cnt_next;
  logic [DIGITS-1:0] an_prev_reg;
  logic [DIGITS-1:0] mask_reg;
  logic [DIGITS-1:0] mask_set;
  logic              change;
  logic              an_onehot;
  logic              do_sample;
  logic [IW-1:0]     sample_idx;

  logic              dec_legal;
  logic              dec_blank;
  logic [3:0]        dec_val;

  assign change    = (an_in != an_prev_reg);
  assign an_onehot = $onehot(an_in);

  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'd0;
    case (seg_in)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: dec_blank = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // A change event always wins: it restarts settling or drops to idle.
  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    do_sample       = 1'b0;
    if (change) begin
      if (an_onehot) begin
        state_next      = (SETTLE == 1) ? ST_SAMPLE : ST_SETTLE;
        settle_cnt_next = SCW'(1);
      end else begin
        state_next = ST_IDLE;
      end
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          settle_cnt_next = settle_cnt_reg + SCW'(1);
          if (int'(settle_cnt_reg) + 1 >= SETTLE)
            state_next = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          do_sample  = 1'b1;
          state_next = ST_HOLD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (an_prev_reg[i])
        sample_idx = IW'(i);
  end

  assign mask_set = mask_reg | (do_sample ? an_prev_reg : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      an_prev_reg    <= '0;
      mask_reg       <= '0;
      frame_valid    <= 1'b0;
      err            <= 1'b0;
      err_digit      <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      an_prev_reg    <= an_in;
      err            <= do_sample && !dec_legal;
      if (do_sample && !dec_legal)
        err_digit <= sample_idx;
      if (do_sample && (&mask_set)) begin
        frame_valid <= 1'b1;
        mask_reg    <= '0;
      end else begin
        frame_valid <= 1'b0;
        mask_reg    <= mask_set;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0]     cand_code_reg;
      logic           cand_blank_reg;
      logic [STW-1:0] cnt_reg;
      logic [STW-1:0] cnt_new;
      logic [3:0]     nib_reg;
      logic           blank_reg;
      logic           hit;
      logic           same;

      assign hit  = do_sample && an_prev_reg[gi];
      assign same = ({dec_blank, dec_val} == {cand_blank_reg, cand_code_reg});

      always_comb begin
        cnt_new = cnt_reg;
        if (!dec_legal)
          cnt_new = '0;
        else if (!same)
          cnt_new = STW'(1);
        else if (int'(cnt_reg) < STABLE)
          cnt_new = cnt_reg + STW'(1);
      end

      // On a legal sample the candidate equals the decoded pattern, so commit that.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cand_code_reg  <= 4'd0;
          cand_blank_reg <= 1'b0;
          cnt_reg        <= '0;
          nib_reg        <= 4'd0;
          blank_reg      <= 1'b1;
        end else if (hit) begin
          cnt_reg <= cnt_new;
          if (dec_legal && !same) begin
            cand_code_reg  <= dec_val;
            cand_blank_reg <= dec_blank;
          end
          if (dec_legal && int'(cnt_new) >= STABLE) begin
            nib_reg   <= dec_val;
            blank_reg <= dec_blank;
          end
        end
      end

      assign digit_out[4*gi +: 4] = nib_reg;
      assign blank_out[gi]        = blank_reg;
    end
  endgenerate

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: table of 6-cycle activations plus corner sequences.
module tb_seven_segment_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h00;
  logic [3:0]  an_in = 4'b0000;
  logic [15:0] digit_out;
  logic [3:0]  blank_out;
  logic        frame_valid;
  logic        err;
  logic [1:0]  err_digit;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  seven_segment_reader #(.DIGITS(4), .SETTLE(3), .STABLE(2)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digit_out(digit_out), .blank_out(blank_out),
    .frame_valid(frame_valid), .err(err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_valid) fv_cnt++;
    if (err) err_cnt++;
  end

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] dig;
    logic [3:0]  blk;
    int          fv;
    int          er;
    logic [1:0]  erd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] an, input logic [6:0] seg, input logic [15:0] dig,
                     input logic [3:0] blk, input int fv, input int er, input logic [1:0] erd);
    vec_t v;
    v.an = an; v.seg = seg; v.dig = dig; v.blk = blk; v.fv = fv; v.er = er; v.erd = erd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in = an;
    seg_in = seg;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_row(input int idx, input string tag);
    int fv0, er0;
    fv0 = fv_cnt;
    er0 = err_cnt;
    drive(vecs[idx].an, vecs[idx].seg, 6);
    chk($sformatf("%s[%0d].digit", tag, idx), 32'(digit_out), 32'(vecs[idx].dig));
    chk($sformatf("%s[%0d].blank", tag, idx), 32'(blank_out), 32'(vecs[idx].blk));
    chk($sformatf("%s[%0d].frame", tag, idx), 32'(fv_cnt - fv0), 32'(vecs[idx].fv));
    chk($sformatf("%s[%0d].err", tag, idx), 32'(err_cnt - er0), 32'(vecs[idx].er));
    chk($sformatf("%s[%0d].errd", tag, idx), 32'(err_digit), 32'(vecs[idx].erd));
    $display("row %s[%0d] an=%b seg=%h digit=%h blank=%b", tag, idx, vecs[idx].an,
             vecs[idx].seg, digit_out, blank_out);
  endtask

  initial begin
    int fv0, er0;
    // scans 1-2: 3F,06,5B,4F
    add(4'b0001, 7'h3F, 16'h0000, 4'hF, 0, 0, 2'd0);
    add(4'b0010, 7'h06, 16'h0000, 4'hF, 0, 0, 2'd0);
    add(4'b0100, 7'h5B, 16'h0000, 4'hF, 0, 0, 2'd0);
    add(4'b1000, 7'h4F, 16'h0000, 4'hF, 1, 0, 2'd0);
    add(4'b0001, 7'h3F, 16'h0000, 4'hE, 0, 0, 2'd0);
    add(4'b0010, 7'h06, 16'h0010, 4'hC, 0, 0, 2'd0);
    add(4'b0100, 7'h5B, 16'h0210, 4'h8, 0, 0, 2'd0);
    add(4'b1000, 7'h4F, 16'h3210, 4'h0, 1, 0, 2'd0);
    // scan 3: illegal 49 on digit 2
    add(4'b0001, 7'h3F, 16'h3210, 4'h0, 0, 0, 2'd0);
    add(4'b0010, 7'h06, 16'h3210, 4'h0, 0, 0, 2'd0);
    add(4'b0100, 7'h49, 16'h3210, 4'h0, 0, 1, 2'd2);
    add(4'b1000, 7'h4F, 16'h3210, 4'h0, 1, 0, 2'd2);
    // scan 4: digit 0 shows 7 once
    add(4'b0001, 7'h07, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b0010, 7'h06, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b0100, 7'h5B, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b1000, 7'h4F, 16'h3210, 4'h0, 1, 0, 2'd2);
    // scans 5-6: digit 0 shows 8
    add(4'b0001, 7'h7F, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b0010, 7'h06, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b0100, 7'h5B, 16'h3210, 4'h0, 0, 0, 2'd2);
    add(4'b1000, 7'h4F, 16'h3210, 4'h0, 1, 0, 2'd2);
    add(4'b0001, 7'h7F, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0010, 7'h06, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0100, 7'h5B, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b1000, 7'h4F, 16'h3218, 4'h0, 1, 0, 2'd2);
    // scans 7-8: digit 3 blank
    add(4'b0001, 7'h7F, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0010, 7'h06, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0100, 7'h5B, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b1000, 7'h00, 16'h3218, 4'h0, 1, 0, 2'd2);
    add(4'b0001, 7'h7F, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0010, 7'h06, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b0100, 7'h5B, 16'h3218, 4'h0, 0, 0, 2'd2);
    add(4'b1000, 7'h00, 16'h0218, 4'h8, 1, 0, 2'd2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.digit", 32'(digit_out), 32'h0000);
    chk("reset.blank", 32'(blank_out), 32'hF);
    chk("reset.frame", 32'(frame_valid), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.errd", 32'(err_digit), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_row(i, "main");

    // multiple enables: no sample
    fv0 = fv_cnt; er0 = err_cnt;
    drive(4'b0011, 7'h49, 10);
    chk("multi_en.frame", 32'(fv_cnt - fv0), 32'd0);
    chk("multi_en.err", 32'(err_cnt - er0), 32'd0);
    chk("multi_en.digit", 32'(digit_out), 32'h0218);
    $display("seq multi_en digit=%h blank=%b", digit_out, blank_out);

    // short enable on digit 0: the following scan cannot complete a frame
    fv0 = fv_cnt; er0 = err_cnt;
    drive(4'b0001, 7'h49, 2);
    drive(4'b0010, 7'h06, 6);
    drive(4'b0100, 7'h5B, 6);
    drive(4'b1000, 7'h00, 6);
    chk("short_en.frame", 32'(fv_cnt - fv0), 32'd0);
    chk("short_en.err", 32'(err_cnt - er0), 32'd0);
    drive(4'b0001, 7'h7F, 6);
    chk("short_en.frame_after_d0", 32'(fv_cnt - fv0), 32'd1);
    chk("short_en.digit", 32'(digit_out), 32'h0218);
    chk("short_en.blank", 32'(blank_out), 32'h8);
    $display("seq short_en digit=%h blank=%b", digit_out, blank_out);

    // asynchronous reset mid-settle
    an_in = 4'b0010; seg_in = 7'h06;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.digit", 32'(digit_out), 32'h0000);
    chk("async_rst.blank", 32'(blank_out), 32'hF);
    chk("async_rst.frame", 32'(frame_valid), 32'd0);
    chk("async_rst.err", 32'(err), 32'd0);
    chk("async_rst.errd", 32'(err_digit), 32'd0);
    $display("seq async_rst digit=%h blank=%b errd=%0d", digit_out, blank_out, err_digit);
    #4 rst = 1'b0;
    @(negedge clk);
    drive(4'b0000, 7'h00, 1);
    for (int i = 0; i < 8; i++)
      run_row(i, "rescan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
